mux2_8b_rr_arbiter: RTL and testbench

- Two-channel 8-bit round-robin arbiter with a registered output slot.
- Sits directly upstream of the 8-bit structural 2:1 mux (mux2_1_8b_struc) and drives its sel line.
- Instantiates that mux on the data path and registers its output, so downstream logic sees a single valid/ready byte stream.
- Also keeps per-channel saturating transfer counters for lab observation.

---
 rtl/mux2_8b_rr_arbiter_pkg.sv | 19 +
 rtl/mux2_8b_rr_arbiter_mux.sv | 30 +++
 rtl/mux2_8b_rr_arbiter.sv | 99 +++++++++
 tb/tb_mux2_8b_rr_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux2_8b_rr_arbiter_pkg.sv
// Shared constants and types for the two-channel round-robin byte arbiter.
package mux2_8b_rr_arbiter_pkg;

  // Source encoding; doubles as the mux select value for that channel.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Default widths. The data-path mux is a fixed 8-bit cell, so W stays 8.
  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 8;

  // Combinational grant decision for the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_A    = 2'b01,
    GNT_B    = 2'b10
  } gnt_e;

endpackage

// File: rtl/mux2_8b_rr_arbiter_mux.sv
// Structural 8-bit 2:1 mux built from one gate-level cell per bit.

// One bit of the mux: y = sel ? b : a, using primitive gates only.
module mux_bit_cell (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  logic ns, ta, tb;
  not u_not (ns, s);
  and u_and0 (ta, a, ns);
  and u_and1 (tb, b, s);
  or  u_or (y, ta, tb);
endmodule

// 8 parallel bit cells sharing the select line.
module mux2_1_8b_struc (
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic       sel,
  output logic [7:0] y
);
  mux_bit_cell u_bit [7:0] (
    .a (in0),
    .b (in1),
    .s (sel),
    .y (y)
  );
endmodule

// File: rtl/mux2_8b_rr_arbiter.sv
// Two-channel round-robin arbiter feeding a structural 2:1 byte mux into a
// single registered output slot, with saturating per-channel transfer counts.
module mux2_8b_rr_arbiter
  import mux2_8b_rr_arbiter_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [W-1:0]     in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic             sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic       last_grant;
  logic       slot_free;
  gnt_e       gnt;
  logic [7:0] mux_y;

  assign slot_free = !out_valid || out_ready;

  // Grant: single requester wins outright; on contention the channel that
  // did not win last time goes. Nothing is granted while reset is held.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst && slot_free) begin
      if (in0_valid && in1_valid)
        gnt = (last_grant == SRC_A) ? GNT_B : GNT_A;
      else if (in0_valid)
        gnt = GNT_A;
      else if (in1_valid)
        gnt = GNT_B;
    end
  end

  // Select follows the grant; when idle it parks on the last winner so the
  // mux select does not toggle needlessly.
  always_comb begin
    sel = last_grant;
    if (gnt == GNT_B)      sel = SRC_B;
    else if (gnt == GNT_A) sel = SRC_A;
  end

  assign in0_ready = (gnt == GNT_A);
  assign in1_ready = (gnt == GNT_B);

  mux2_1_8b_struc u_mux (
    .in0 (in0_data),
    .in1 (in1_data),
    .sel (sel),
    .y   (mux_y)
  );

  // Output slot: load on a grant, drain on consume, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_src    <= SRC_A;
      last_grant <= SRC_B;
    end else if (gnt != GNT_NONE) begin
      out_data   <= mux_y;
      out_valid  <= 1'b1;
      out_src    <= sel;
      last_grant <= sel;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Channel A transfer counter: clear wins over increment, sticks at max.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      cnt_a <= '0;
    else if (in0_ready && (cnt_a != {CNT_W{1'b1}}))
      cnt_a <= cnt_a + 1'b1;
  end

  // Channel B transfer counter: same rules as channel A.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      cnt_b <= '0;
    else if (in1_ready && (cnt_b != {CNT_W{1'b1}}))
      cnt_b <= cnt_b + 1'b1;
  end

endmodule

// File: tb/tb_mux2_8b_rr_arbiter.sv
// Bench for mux2_8b_rr_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the arbiter.
module tb_mux2_8b_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in0_data, in1_data;
  logic       in0_valid, in1_valid;
  logic       in0_ready, in1_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_src, sel;
  logic       cnt_clr;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux2_8b_rr_arbiter #(.W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .sel       (sel),
    .cnt_clr   (cnt_clr),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State: what the output slot holds, who won last, and the two counts.
  logic       m_v, m_src, m_last;
  logic [7:0] m_data;
  int         m_ca, m_cb;
  bit         armed = 0;

  // Who gets served this cycle: 0 nobody, 1 channel A, 2 channel B.
  function automatic int model_grant();
    if (rst) return 0;
    if (m_v && !out_ready) return 0;
    if (in0_valid && in1_valid) return (m_last == 1'b1) ? 1 : 2;
    if (in0_valid) return 1;
    if (in1_valid) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    int g;
    g = model_grant();
    if (rst) begin
      m_v = 0; m_src = 0; m_last = 1; m_data = 8'h00; m_ca = 0; m_cb = 0;
      armed = 1;
    end else begin
      if (g != 0) begin
        m_data = (g == 2) ? in1_data : in0_data;
        m_v    = 1;
        m_src  = (g == 2);
        m_last = (g == 2);
      end else if (out_ready) begin
        m_v = 0;
      end
      if (cnt_clr) begin
        m_ca = 0; m_cb = 0;
      end else begin
        if (g == 1 && m_ca < 255) m_ca++;
        if (g == 2 && m_cb < 255) m_cb++;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    int g;
    if (armed) begin
      g = model_grant();
      chk("in0_ready", in0_ready, g == 1);
      chk("in1_ready", in1_ready, g == 2);
      chk("sel", sel, (g == 2) ? 1'b1 : (g == 1) ? 1'b0 : m_last);
      chk("out_valid", out_valid, m_v);
      chk("out_data", out_data, m_data);
      chk("out_src", out_src, m_src);
      chk("cnt_a", cnt_a, m_ca[7:0]);
      chk("cnt_b", cnt_b, m_cb[7:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; cnt_clr = 0; out_ready = 1;
    in0_valid = 1; in1_valid = 1; in0_data = 8'h11; in1_data = 8'h22;

    // Reset held two cycles with both channels requesting.
    step(); step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_out_data", out_data, 0);

    // Release: A wins first contention.
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("first_in0_ready", in0_ready, 1);
    chk("first_sel", sel, 0);

    // Strict alternation over six transfers; the sixth ends under backpressure.
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 5) out_ready = 0;
      @(negedge clk);
      chk("alt_data", out_data, (i % 2) ? 8'h22 : 8'h11);
      chk("alt_src", out_src, i % 2);
    end
    chk("alt_cnt_a", cnt_a, 3);
    chk("alt_cnt_b", cnt_b, 3);

    // Backpressure for three cycles: everything frozen.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in0_ready", in0_ready, 0);
      chk("bp_in1_ready", in1_ready, 0);
      chk("bp_data", out_data, 8'h22);
      chk("bp_cnt_a", cnt_a, 3);
      step();
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_grant_a", in0_ready, 1);

    // Single source B, four back-to-back transfers.
    step();
    in0_valid = 0; in1_data = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("single_in1_ready", in1_ready, 1);
      chk("single_in0_ready", in0_ready, 0);
      step();
      @(negedge clk);
      chk("single_data", out_data, 8'hA5);
    end
    in1_valid = 0;

    // Saturation: 260 A transfers pin cnt_a at 0xFF.
    in0_valid = 1; in0_data = 8'h3C;
    for (int i = 0; i < 260; i++) step();
    @(negedge clk);
    chk("sat_cnt_a", cnt_a, 8'hFF);
    chk("sat_accept", in0_ready, 1);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    @(negedge clk);
    chk("clr_cnt_a", cnt_a, 0);

    // Reset while the slot holds 0x22.
    in0_valid = 0; in1_valid = 1; in1_data = 8'h22;
    step();
    in1_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("mid_hold", out_data, 8'h22);
    rst = 1;
    step();
    rst = 0; out_ready = 1; in0_valid = 1; in1_valid = 1; in0_data = 8'h11;
    @(negedge clk);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_grant_a", in0_ready, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      in0_valid = ($urandom_range(9) < 7);
      in1_valid = ($urandom_range(9) < 6);
      in0_data  = 8'($urandom);
      in1_data  = 8'($urandom);
      out_ready = ($urandom_range(9) < 7);
      cnt_clr   = ($urandom_range(99) < 3);
      rst       = ($urandom_range(199) == 0);
    end
    step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
